// File: rtl/branch_resolver_if.sv
// Branch-resolver handshake bundle: EX-stage branch input, predictor feedback,
// fetch redirect and statistics counters.
interface branch_resolver_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_valid;
  logic                  i_is_jump;
  logic [ADDR_WIDTH-1:0] i_pc;
  logic [2:0]            i_cond;
  logic [DATA_WIDTH-1:0] i_rs_data;
  logic [DATA_WIDTH-1:0] i_rt_data;
  logic                  i_prediction;
  logic [ADDR_WIDTH-1:0] i_recovery_target;
  logic                  o_stall;
  logic                  o_fb_valid;
  logic [ADDR_WIDTH-1:0] o_fb_pc;
  logic                  o_fb_prediction;
  logic                  o_fb_outcome;
  logic                  o_flush;
  logic                  o_redirect_valid;
  logic [ADDR_WIDTH-1:0] o_redirect_target;
  logic                  i_redirect_ready;
  logic [CNT_WIDTH-1:0]  o_branch_count;
  logic [CNT_WIDTH-1:0]  o_miss_count;

  modport master (
    output i_valid, i_is_jump, i_pc, i_cond, i_rs_data, i_rt_data,
           i_prediction, i_recovery_target, i_redirect_ready,
    input  o_stall, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
           o_flush, o_redirect_valid, o_redirect_target,
           o_branch_count, o_miss_count
  );

  modport slave (
    input  i_valid, i_is_jump, i_pc, i_cond, i_rs_data, i_rt_data,
           i_prediction, i_recovery_target, i_redirect_ready,
    output o_stall, o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
           o_flush, o_redirect_valid, o_redirect_target,
           o_branch_count, o_miss_count
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage conditional branch resolver: predictor feedback, mispredict
// flush/redirect handshake and saturating statistics.
module branch_resolver #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bif
);
  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t                state;
  logic                  outcome, accept, miss;
  logic                  fb_valid, fb_prediction, fb_outcome, flush, redirect_valid;
  logic [ADDR_WIDTH-1:0] fb_pc, redirect_target;
  logic [CNT_WIDTH-1:0]  branch_cnt, miss_cnt;

  always_comb begin
    outcome = 1'b0;
    case (bif.i_cond)
      3'd0:    outcome = (bif.i_rs_data == bif.i_rt_data);
      3'd1:    outcome = (bif.i_rs_data != bif.i_rt_data);
      3'd2:    outcome = ($signed(bif.i_rs_data) <= $signed(DATA_WIDTH'(0)));
      3'd3:    outcome = ($signed(bif.i_rs_data) >  $signed(DATA_WIDTH'(0)));
      3'd4:    outcome = bif.i_rs_data[DATA_WIDTH-1];
      3'd5:    outcome = ~bif.i_rs_data[DATA_WIDTH-1];
      default: outcome = 1'b0;
    endcase
  end

  // Redirect in flight blocks acceptance, including the cycle ready is seen.
  assign accept = bif.i_valid & ~bif.i_is_jump & (state == IDLE);
  assign miss   = outcome != bif.i_prediction;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fb_valid        <= 1'b0;
      fb_pc           <= '0;
      fb_prediction   <= 1'b0;
      fb_outcome      <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
      branch_cnt      <= '0;
      miss_cnt        <= '0;
    end else begin
      fb_valid <= accept;
      flush    <= accept & miss;
      if (accept) begin
        fb_pc         <= bif.i_pc;
        fb_prediction <= bif.i_prediction;
        fb_outcome    <= outcome;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_WIDTH'(1);
        if (miss && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      end
      case (state)
        IDLE: if (accept && miss) begin
          state           <= REDIRECT;
          redirect_valid  <= 1'b1;
          redirect_target <= bif.i_recovery_target;
        end
        REDIRECT: if (bif.i_redirect_ready) begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bif.o_stall           = (state == REDIRECT);
  assign bif.o_fb_valid        = fb_valid;
  assign bif.o_fb_pc           = fb_pc;
  assign bif.o_fb_prediction   = fb_prediction;
  assign bif.o_fb_outcome      = fb_outcome;
  assign bif.o_flush           = flush;
  assign bif.o_redirect_valid  = redirect_valid;
  assign bif.o_redirect_target = redirect_target;
  assign bif.o_branch_count    = branch_cnt;
  assign bif.o_miss_count      = miss_cnt;
endmodule
